dev_hex_loader: RTL and testbench
=================================

# dev_hex_loader

Parametrised ASCII-hex program loader that sits between the UART receive path and the RAM device. It consumes one character per `data_en` strobe and assembles hex digit pairs into bytes. Bytes are packed into `WORD_BYTES`-wide words, and each word is written to RAM with per-byte enables. Beyond plain byte streams, it supports `@addr` load-address directives, `#` line comments, an explicit `$` end marker and sticky error detection.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the byte address; the address space wraps modulo 2^ADDR_W.
- `WORD_BYTES`, default 4: bytes per RAM write. Legal values: 1, 2, 4, 8.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_in` in 8: ASCII character; valid when `data_en` is high.
- `data_en` in 1: one-cycle strobe per character; may be high on consecutive cycles.
- `wr_en` in→out 1 (output): one-cycle RAM write strobe.
- `wr_addr` out ADDR_W: byte address of lane 0 of the written word; always WORD_BYTES-aligned.
- `wr_data` out 8·WORD_BYTES: the byte for offset k is in `wr_data[8k+7:8k]`; lanes not enabled are 0.
- `wr_be` out WORD_BYTES: byte enables, one bit per lane.
- `byte_valid` out 1: one-cycle pulse when a data byte completes.
- `byte_count` out ADDR_W+1: number of data bytes accepted since reset; saturates at all-ones.
- `done` out 1: sticky; the load finished successfully.
- `error` out 1: sticky; a syntax or checksum error occurred.
- `cksum` out 8: running 8-bit sum of data bytes. Driven 0 when the checksum feature is compiled out.

## Operation
Every output resets to 0, and the internal address and lane also reset to 0. The block has six states: `DATA`, `NIB`, `ADDR`, `COMMENT`, `DONE`, `ERR`.

- **`DATA`** (entered after reset):
  - Hex digit (`0-9`, `a-f`, `A-F`): latch the high nibble, go to `NIB`.
  - Whitespace (space, TAB, CR, LF): ignored.
  - `#`: go to `COMMENT`.
  - `@`: flush the pending word, clear the address accumulator, go to `ADDR`.
  - `$`: flush, then go to `DONE`.
  - Any other character: go to `ERR`.
- **`NIB`**:
  - Hex digit: complete the byte, store it in lane `addr mod WORD_BYTES`, set that lane's enable bit, increment the address, pulse `byte_valid`, update `cksum`. If the lane was `WORD_BYTES-1`, issue the write. Return to `DATA`.
  - Any other character: go to `ERR`.
- **`ADDR`**:
  - Hex digit: shift it into the accumulator. More than ceil(ADDR_W/4) digits goes to `ERR`.
  - Whitespace with at least one digit received: load the address and return to `DATA`.
  - Whitespace with zero digits, or any other character: go to `ERR`.
- **`COMMENT`**: discard characters until LF, then return to `DATA`.
- **Flush**: if any lane enable is set, issue a write with a partial `wr_be`. Otherwise no write.
- **`DONE` / `ERR`**: absorbing; all input is ignored until `rst`. Entering `ERR` discards the pending partial word; no write occurs.
- **Address wrap**: an increment past 2^ADDR_W−1 wraps to 0. Because wrapping also crosses a word boundary, the current word is written first.
- **Reset mid-load**: the partial word is discarded, no write occurs, and the block returns to `DATA` at address 0.

## Timing
- A character strobed at cycle T is decoded at T. Any resulting `wr_en`, `wr_addr`, `wr_data`, `wr_be`, `byte_valid`, `done` or `error` is registered and visible at T+1.
- `wr_en` is high for exactly one cycle per write. Lane registers clear at T+1, so a character at T+1 starts a fresh word; back-to-back strobes lose nothing.
- A `$` at T with a partial word pending: the flush `wr_en` and `done` both rise at T+1.
- `byte_count` and `cksum` update at T+1 together with `byte_valid`.

## Configuration
- **`HEX_LOADER_CKSUM_EN` defined**:
  - `$` is followed by exactly two hex digits C, with no whitespace between them; the block passes through a `CKSUM` state to collect them.
  - After the second digit: if `(cksum + C) mod 256 == 0`, flush and go to `DONE`; otherwise discard the pending word and go to `ERR`.
  - A non-hex character inside `CKSUM` goes to `ERR`.
- **Undefined**: `$` terminates immediately; `cksum` is tied to 0 and the `CKSUM` state is absent.

## Test plan
All scenarios use ADDR_W=16, WORD_BYTES=4 and start after reset.
1. `01 02 03 04 $` → one write: addr 0x0000, data 0x04030201, be 4'hF. Then `done`=1, `byte_count`=4, four `byte_valid` pulses.
2. `@0102 aa bb $` → one write: addr 0x0100, be 4'b1100, data 0xBBAA0000. Then `done`=1.
3. `@FFFE 11 22 33 $` → write addr 0xFFFC, be 4'b1100, data 0x22110000; then write addr 0x0000, be 4'b0001, data 0x00000033.
4. `# hi\n7f$` → comment skipped; write addr 0x0000, be 4'b0001, data 0x7F.
5. `1G` → `error`=1 at the cycle after `G`, no write. A following `22$` leaves all outputs unchanged.
6. Checksum, with `HEX_LOADER_CKSUM_EN` defined:
   - `01 02 $FD` → write data 0x0201, be 4'b0011, then `done`=1.
   - `01 02 $FC` → `error`=1, no write.

Source files
------------

// File: rtl/dev_hex_loader.sv
// dev_hex_loader: ASCII-hex program loader between the UART receive path and RAM.
// Assembles hex digit pairs into bytes and packs them into WORD_BYTES-wide RAM
// writes with per-byte enables. Understands '@addr' directives, '#' line
// comments and a '$' end marker. Errors are sticky until reset.
// Optional feature macro: HEX_LOADER_CKSUM_EN adds a two-digit checksum after '$'.
module dev_hex_loader #(
    parameter int ADDR_W     = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              data_in,
    input  logic                    data_en,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic [WORD_BYTES-1:0]   wr_be,
    output logic                    byte_valid,
    output logic [ADDR_W:0]         byte_count,
    output logic                    done,
    output logic                    error,
    output logic [7:0]              cksum
);

    localparam int NDIG   = (ADDR_W + 3) / 4;
    localparam int ACC_W  = 4 * NDIG;
    localparam int CNT_W  = $clog2(NDIG + 2);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_DATA, S_NIB, S_ADDR, S_COMMENT, S_DONE, S_ERR
`ifdef HEX_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        ndig_q;
    logic [3:0]              hi_q;
    logic [8*WORD_BYTES-1:0] buf_q;
    logic [WORD_BYTES-1:0]   be_q;
    logic [7:0]              cksum_q;
`ifdef HEX_LOADER_CKSUM_EN
    logic                    ck_have_q;
`endif

    logic                    is_hex, is_ws;
    logic [3:0]              nib;
    logic [7:0]              byte_d;
    logic [LANE_W-1:0]       lane;
    logic [8*WORD_BYTES-1:0] buf_d;
    logic [WORD_BYTES-1:0]   be_d;
    logic [ADDR_W-1:0]       base;

    // Character classification and the word image with the completing byte merged in
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (data_in >= "0" && data_in <= "9")
            nib = data_in[3:0];
        else if ((data_in >= "a" && data_in <= "f") || (data_in >= "A" && data_in <= "F"))
            nib = data_in[3:0] + 4'd9;
        else
            is_hex = 1'b0;
        is_ws  = (data_in == 8'h20) || (data_in == 8'h09) ||
                 (data_in == 8'h0D) || (data_in == 8'h0A);
        byte_d = {hi_q, nib};
        lane   = LANE_W'(addr_q & LANE_MASK);
        base   = addr_q & ~LANE_MASK;
        buf_d  = buf_q;
        buf_d[8*int'(lane) +: 8] = byte_d;
        be_d   = be_q;
        be_d[lane] = 1'b1;
    end

    // Loader FSM: decode one character per strobe, register every output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_DATA;
            addr_q     <= '0;
            acc_q      <= '0;
            ndig_q     <= '0;
            hi_q       <= '0;
            buf_q      <= '0;
            be_q       <= '0;
            cksum_q    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            byte_valid <= 1'b0;
            byte_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef HEX_LOADER_CKSUM_EN
            ck_have_q  <= 1'b0;
`endif
        end else begin
            wr_en      <= 1'b0;
            byte_valid <= 1'b0;
            if (data_en) begin
                case (state_q)
                    S_DATA: begin
                        if (is_hex) begin
                            hi_q    <= nib;
                            state_q <= S_NIB;
                        end else if (is_ws) begin
                            state_q <= S_DATA;
                        end else if (data_in == "#") begin
                            state_q <= S_COMMENT;
                        end else if (data_in == "@") begin
                            if (|be_q) begin
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= buf_q;
                                wr_be   <= be_q;
                            end
                            buf_q   <= '0;
                            be_q    <= '0;
                            acc_q   <= '0;
                            ndig_q  <= '0;
                            state_q <= S_ADDR;
                        end else if (data_in == "$") begin
`ifdef HEX_LOADER_CKSUM_EN
                            // Flush is deferred until the checksum verifies
                            ck_have_q <= 1'b0;
                            state_q   <= S_CKSUM;
`else
                            if (|be_q) begin
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= buf_q;
                                wr_be   <= be_q;
                            end
                            buf_q   <= '0;
                            be_q    <= '0;
                            done    <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            buf_q   <= '0;
                            be_q    <= '0;
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    S_NIB: begin
                        if (is_hex) begin
                            byte_valid <= 1'b1;
                            if (byte_count != '1)
                                byte_count <= byte_count + 1'b1;
                            cksum_q <= cksum_q + byte_d;
                            addr_q  <= addr_q + 1'b1;
                            // Last lane closes the word; this also covers the address wrap
                            if (lane == LANE_W'(WORD_BYTES - 1)) begin
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= buf_d;
                                wr_be   <= be_d;
                                buf_q   <= '0;
                                be_q    <= '0;
                            end else begin
                                buf_q   <= buf_d;
                                be_q    <= be_d;
                            end
                            state_q <= S_DATA;
                        end else begin
                            buf_q   <= '0;
                            be_q    <= '0;
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    S_ADDR: begin
                        if (is_hex && ndig_q != CNT_W'(NDIG)) begin
                            acc_q   <= (acc_q << 4) | ACC_W'(nib);
                            ndig_q  <= ndig_q + 1'b1;
                        end else if (is_ws && ndig_q != '0) begin
                            addr_q  <= acc_q[ADDR_W-1:0];
                            state_q <= S_DATA;
                        end else begin
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    S_COMMENT: begin
                        if (data_in == 8'h0A)
                            state_q <= S_DATA;
                    end
`ifdef HEX_LOADER_CKSUM_EN
                    S_CKSUM: begin
                        if (!is_hex) begin
                            buf_q   <= '0;
                            be_q    <= '0;
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end else if (!ck_have_q) begin
                            hi_q      <= nib;
                            ck_have_q <= 1'b1;
                        end else if (8'(cksum_q + byte_d) == 8'h00) begin
                            if (|be_q) begin
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= buf_q;
                                wr_be   <= be_q;
                            end
                            buf_q   <= '0;
                            be_q    <= '0;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            buf_q   <= '0;
                            be_q    <= '0;
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
`endif
                    default: state_q <= state_q;  // DONE / ERR absorb everything
                endcase
            end
        end
    end

`ifdef HEX_LOADER_CKSUM_EN
    assign cksum = cksum_q;
`else
    assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_dev_hex_loader.sv
// Directed bench for dev_hex_loader (ADDR_W=16, WORD_BYTES=4).
module tb_dev_hex_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_en;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        byte_valid;
    logic [16:0] byte_count;
    logic        done;
    logic        error;
    logic [7:0]  cksum;

`ifdef HEX_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int bv_cnt;
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];

    dev_hex_loader #(.ADDR_W(16), .WORD_BYTES(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .byte_valid(byte_valid), .byte_count(byte_count), .done(done),
        .error(error), .cksum(cksum)
    );

    always #5 clk = ~clk;

    // Log writes and byte pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                q_addr.push_back(wr_addr);
                q_data.push_back(wr_data);
                q_be.push_back(wr_be);
            end
            if (byte_valid) bv_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_en = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_data.delete();
        q_be.delete();
        bv_cnt = 0;
        rst = 1'b0;
    endtask

    // Back-to-back strobes; returns at the negedge after the last character's edge
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            data_in = s[i];
            data_en = 1'b1;
            @(negedge clk);
        end
        data_en = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_be", wr_be, 0);
        chk("rst_flags", {byte_valid, done, error}, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_cksum", cksum, 0);

        // 1: full word
        send("01 02 03 04 $");
        if (CK) send("F6");
        idle();
        chk("s1_nwr", q_addr.size(), 1);
        chk("s1_addr", q_addr[0], 16'h0000);
        chk("s1_data", q_data[0], 32'h04030201);
        chk("s1_be", q_be[0], 4'hF);
        chk("s1_done", {done, error}, 2'b10);
        chk("s1_count", byte_count, 4);
        chk("s1_bv", bv_cnt, 4);
        chk("s1_cksum", cksum, CK ? 8'h0A : 8'h00);

        // 2: address directive with upper-lane partial word
        do_reset();
        send("@0102 aa bb $");
        if (CK) send("9B");
        idle();
        chk("s2_nwr", q_addr.size(), 1);
        chk("s2_addr", q_addr[0], 16'h0100);
        chk("s2_data", q_data[0], 32'hBBAA0000);
        chk("s2_be", q_be[0], 4'b1100);
        chk("s2_done", done, 1);
        chk("s2_cksum", cksum, CK ? 8'h65 : 8'h00);

        // 3: address wrap
        do_reset();
        send("@FFFE 11 22 33 $");
        if (CK) send("9A");
        idle();
        chk("s3_nwr", q_addr.size(), 2);
        chk("s3_addr0", q_addr[0], 16'hFFFC);
        chk("s3_data0", q_data[0], 32'h22110000);
        chk("s3_be0", q_be[0], 4'b1100);
        chk("s3_addr1", q_addr[1], 16'h0000);
        chk("s3_data1", q_data[1], 32'h00000033);
        chk("s3_be1", q_be[1], 4'b0001);
        chk("s3_count", byte_count, 3);

        // 4: comment, and flush write coinciding with done
        do_reset();
        send("# hi\n7f$");
        if (CK) send("81");
        chk("s4_t1", {wr_en, done}, 2'b11);
        idle();
        chk("s4_nwr", q_addr.size(), 1);
        chk("s4_addr", q_addr[0], 16'h0000);
        chk("s4_data", q_data[0], 32'h0000007F);
        chk("s4_be", q_be[0], 4'b0001);

        // 5: bad second nibble, then absorbing error
        do_reset();
        send("1G");
        chk("s5_err_t1", error, 1);
        send("22$");
        if (CK) send("DE");
        idle();
        chk("s5_err", {done, error}, 2'b01);
        chk("s5_nwr", q_addr.size(), 0);
        chk("s5_count", byte_count, 0);
        chk("s5_bv", bv_cnt, 0);
        chk("s5_outs", {wr_addr, wr_data, wr_be}, 0);

        // too many address digits
        do_reset();
        send("@12345 ");
        idle();
        chk("addr_long", error, 1);

        // address directive without digits
        do_reset();
        send("@ 01");
        idle();
        chk("addr_empty", error, 1);
        chk("addr_empty_bv", bv_cnt, 0);

        // reset mid-load drops the partial word
        do_reset();
        send("0102");
        do_reset();
        send("05$");
        if (CK) send("FB");
        idle();
        chk("midrst_nwr", q_addr.size(), 1);
        chk("midrst_data", q_data[0], 32'h00000005);
        chk("midrst_be", q_be[0], 4'b0001);
        chk("midrst_count", byte_count, 1);

`ifdef HEX_LOADER_CKSUM_EN
        do_reset();
        send("01 02 $FD");
        idle();
        chk("ck_ok_nwr", q_addr.size(), 1);
        chk("ck_ok_data", q_data[0], 32'h00000201);
        chk("ck_ok_be", q_be[0], 4'b0011);
        chk("ck_ok_done", {done, error}, 2'b10);

        do_reset();
        send("01 02 $FC");
        idle();
        chk("ck_bad_err", {done, error}, 2'b01);
        chk("ck_bad_nwr", q_addr.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
